pr_ex_mem: RTL and testbench

PR_EX_MEM -- requirements
Module: pr_ex_mem

---
 rtl/pr_ex_mem.sv | 155 +++++++++++++++
 tb/tb_pr_ex_mem.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_ex_mem.sv
// EX/MEM pipeline register with a two-state data-memory handshake.
// Memory ops stall EX until the memory acks; misaligned ops are flagged and never issued.
module pr_ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] pc_ex_i,
  input  logic [31:0] pc4_ex_i,
  input  logic [31:0] alu_result_ex_i,
  input  logic [31:0] rD2_ex_i,
  input  logic        instr_valid_ex_i,
  input  logic        rf_we_ex_i,
  input  logic        dram_we_ex_i,
  input  logic        is_load_ex_i,
  input  logic [1:0]  wd_sel_ex_i,
  input  logic [4:0]  wr_ex_i,
  input  logic [1:0]  mem_size_ex_i,
  input  logic        load_uns_ex_i,
  output logic [31:0] pc_mem_o,
  output logic [31:0] pc4_mem_o,
  output logic [31:0] alu_result_mem_o,
  output logic        instr_valid_mem_o,
  output logic        rf_we_mem_o,
  output logic [1:0]  wd_sel_mem_o,
  output logic [4:0]  wr_mem_o,
  output logic [1:0]  mem_size_mem_o,
  output logic        load_uns_mem_o,
  output logic [1:0]  byte_off_mem_o,
  output logic        misalign_mem_o,
  output logic        dram_req_o,
  output logic        dram_we_o,
  output logic [31:0] dram_addr_o,
  output logic [31:0] dram_wdata_o,
  output logic [3:0]  dram_be_o,
  input  logic        dram_ack_i,
  input  logic [31:0] dram_rdata_i,
  output logic [31:0] load_data_mem_o,
  output logic        stall_ex_o
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg, pc4_reg, alu_reg, rd2_reg, load_data_reg;
  logic        valid_reg, rf_we_reg, dram_we_reg, is_load_reg, load_uns_reg, misalign_reg;
  logic [1:0]  wd_sel_reg, mem_size_reg;
  logic [4:0]  wr_reg;

  logic        hold;
  logic        mem_op_ex;
  logic        misalign_ex;
  logic [1:0]  off;

  assign hold      = (state_reg == WAIT) && !dram_ack_i;
  assign mem_op_ex = instr_valid_ex_i && (is_load_ex_i || dram_we_ex_i);

  // Reserved size 2'b11 is treated as a word access.
  always_comb begin
    misalign_ex = 1'b0;
    case (mem_size_ex_i)
      2'b00:   misalign_ex = 1'b0;
      2'b01:   misalign_ex = alu_result_ex_i[0];
      default: misalign_ex = |alu_result_ex_i[1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      pc_reg        <= '0;
      pc4_reg       <= '0;
      alu_reg       <= '0;
      rd2_reg       <= '0;
      valid_reg     <= 1'b0;
      rf_we_reg     <= 1'b0;
      dram_we_reg   <= 1'b0;
      is_load_reg   <= 1'b0;
      wd_sel_reg    <= '0;
      wr_reg        <= '0;
      mem_size_reg  <= '0;
      load_uns_reg  <= 1'b0;
      misalign_reg  <= 1'b0;
      load_data_reg <= '0;
    end else begin
      if (state_reg == WAIT && dram_ack_i && is_load_reg)
        load_data_reg <= dram_rdata_i;
      // A stall holds everything, including a pending flush request.
      if (!hold) begin
        if (flush_i) begin
          state_reg    <= IDLE;
          pc_reg       <= '0;
          pc4_reg      <= '0;
          alu_reg      <= '0;
          rd2_reg      <= '0;
          valid_reg    <= 1'b0;
          rf_we_reg    <= 1'b0;
          dram_we_reg  <= 1'b0;
          is_load_reg  <= 1'b0;
          wd_sel_reg   <= '0;
          wr_reg       <= '0;
          mem_size_reg <= '0;
          load_uns_reg <= 1'b0;
          misalign_reg <= 1'b0;
        end else begin
          state_reg    <= (mem_op_ex && !misalign_ex) ? WAIT : IDLE;
          pc_reg       <= pc_ex_i;
          pc4_reg      <= pc4_ex_i;
          alu_reg      <= alu_result_ex_i;
          rd2_reg      <= rD2_ex_i;
          valid_reg    <= instr_valid_ex_i;
          rf_we_reg    <= rf_we_ex_i && !(mem_op_ex && misalign_ex);
          dram_we_reg  <= dram_we_ex_i;
          is_load_reg  <= is_load_ex_i;
          wd_sel_reg   <= wd_sel_ex_i;
          wr_reg       <= wr_ex_i;
          mem_size_reg <= mem_size_ex_i;
          load_uns_reg <= load_uns_ex_i;
          misalign_reg <= mem_op_ex && misalign_ex;
        end
      end
    end
  end

  assign off               = alu_reg[1:0];
  assign pc_mem_o          = pc_reg;
  assign pc4_mem_o         = pc4_reg;
  assign alu_result_mem_o  = alu_reg;
  assign instr_valid_mem_o = valid_reg;
  assign rf_we_mem_o       = rf_we_reg;
  assign wd_sel_mem_o      = wd_sel_reg;
  assign wr_mem_o          = wr_reg;
  assign mem_size_mem_o    = mem_size_reg;
  assign load_uns_mem_o    = load_uns_reg;
  assign byte_off_mem_o    = off;
  assign misalign_mem_o    = misalign_reg;
  assign load_data_mem_o   = load_data_reg;

  assign dram_req_o   = (state_reg == WAIT);
  assign dram_we_o    = dram_we_reg;
  assign dram_addr_o  = {alu_reg[31:2], 2'b00};
  assign dram_wdata_o = rd2_reg << {off, 3'b000};
  assign stall_ex_o   = hold;

  // Half accesses only reach WAIT when aligned, so lane pairs split on off[1].
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_be
      localparam logic [1:0] LANE = 2'(gi);
      assign dram_be_o[gi] = dram_req_o &
                             ((mem_size_reg == 2'b00) ? (off == LANE) :
                              (mem_size_reg == 2'b01) ? (off[1] == LANE[1]) : 1'b1);
    end
  endgenerate

endmodule

// File: tb/tb_pr_ex_mem.sv
// Bench for pr_ex_mem: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model of the MEM stage.
module tb_pr_ex_mem;

  logic        clk = 1'b0;
  logic        rst, flush_i;
  logic [31:0] pc_ex_i, pc4_ex_i, alu_result_ex_i, rD2_ex_i;
  logic        instr_valid_ex_i, rf_we_ex_i, dram_we_ex_i, is_load_ex_i, load_uns_ex_i;
  logic [1:0]  wd_sel_ex_i, mem_size_ex_i;
  logic [4:0]  wr_ex_i;
  logic [31:0] pc_mem_o, pc4_mem_o, alu_result_mem_o;
  logic        instr_valid_mem_o, rf_we_mem_o, load_uns_mem_o, misalign_mem_o;
  logic [1:0]  wd_sel_mem_o, mem_size_mem_o, byte_off_mem_o;
  logic [4:0]  wr_mem_o;
  logic        dram_req_o, dram_we_o, dram_ack_i, stall_ex_o;
  logic [31:0] dram_addr_o, dram_wdata_o, dram_rdata_i, load_data_mem_o;
  logic [3:0]  dram_be_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model of the MEM-side state
  logic [31:0] m_pc, m_pc4, m_alu, m_rd2, m_ld_data;
  logic        m_valid, m_rfwe, m_we, m_ld, m_uns, m_mis, m_wait;
  logic [1:0]  m_wdsel, m_size;
  logic [4:0]  m_wr;

  pr_ex_mem dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .pc_ex_i(pc_ex_i), .pc4_ex_i(pc4_ex_i), .alu_result_ex_i(alu_result_ex_i), .rD2_ex_i(rD2_ex_i),
    .instr_valid_ex_i(instr_valid_ex_i), .rf_we_ex_i(rf_we_ex_i), .dram_we_ex_i(dram_we_ex_i),
    .is_load_ex_i(is_load_ex_i), .wd_sel_ex_i(wd_sel_ex_i), .wr_ex_i(wr_ex_i),
    .mem_size_ex_i(mem_size_ex_i), .load_uns_ex_i(load_uns_ex_i),
    .pc_mem_o(pc_mem_o), .pc4_mem_o(pc4_mem_o), .alu_result_mem_o(alu_result_mem_o),
    .instr_valid_mem_o(instr_valid_mem_o), .rf_we_mem_o(rf_we_mem_o), .wd_sel_mem_o(wd_sel_mem_o),
    .wr_mem_o(wr_mem_o), .mem_size_mem_o(mem_size_mem_o), .load_uns_mem_o(load_uns_mem_o),
    .byte_off_mem_o(byte_off_mem_o), .misalign_mem_o(misalign_mem_o),
    .dram_req_o(dram_req_o), .dram_we_o(dram_we_o), .dram_addr_o(dram_addr_o),
    .dram_wdata_o(dram_wdata_o), .dram_be_o(dram_be_o), .dram_ack_i(dram_ack_i),
    .dram_rdata_i(dram_rdata_i), .load_data_mem_o(load_data_mem_o), .stall_ex_o(stall_ex_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  task automatic model_clear_fields();
    m_pc = 0; m_pc4 = 0; m_alu = 0; m_rd2 = 0;
    m_valid = 0; m_rfwe = 0; m_we = 0; m_ld = 0; m_uns = 0; m_mis = 0; m_wait = 0;
    m_wdsel = 0; m_size = 0; m_wr = 0;
  endtask

  // Applied on each rising edge using the inputs presented during that cycle.
  task automatic model_update();
    logic stall_now, mem;
    int   off;
    if (rst) begin
      model_clear_fields();
      m_ld_data = 0;
      return;
    end
    stall_now = m_wait && !dram_ack_i;
    if (m_wait && dram_ack_i && m_ld) m_ld_data = dram_rdata_i;
    if (stall_now) return;
    if (flush_i) begin
      model_clear_fields();
      return;
    end
    mem     = instr_valid_ex_i && (is_load_ex_i || dram_we_ex_i);
    off     = int'(alu_result_ex_i % 4);
    m_mis   = mem && (off % size_bytes(mem_size_ex_i) != 0);
    m_wait  = mem && !m_mis;
    m_rfwe  = rf_we_ex_i && !m_mis;
    m_pc = pc_ex_i; m_pc4 = pc4_ex_i; m_alu = alu_result_ex_i; m_rd2 = rD2_ex_i;
    m_valid = instr_valid_ex_i; m_we = dram_we_ex_i; m_ld = is_load_ex_i;
    m_uns = load_uns_ex_i; m_wdsel = wd_sel_ex_i; m_size = mem_size_ex_i; m_wr = wr_ex_i;
  endtask

  task automatic compare_all();
    int          off, be;
    logic [31:0] wd;
    off = int'(m_alu % 4);
    be  = m_wait ? ((((1 << size_bytes(m_size)) - 1) << off) & 15) : 0;
    wd  = m_rd2 << (8 * off);
    chk("pc",        pc_mem_o, m_pc);
    chk("pc4",       pc4_mem_o, m_pc4);
    chk("alu",       alu_result_mem_o, m_alu);
    chk("valid",     32'(instr_valid_mem_o), 32'(m_valid));
    chk("rf_we",     32'(rf_we_mem_o), 32'(m_rfwe));
    chk("wd_sel",    32'(wd_sel_mem_o), 32'(m_wdsel));
    chk("wr",        32'(wr_mem_o), 32'(m_wr));
    chk("mem_size",  32'(mem_size_mem_o), 32'(m_size));
    chk("load_uns",  32'(load_uns_mem_o), 32'(m_uns));
    chk("byte_off",  32'(byte_off_mem_o), 32'(off));
    chk("misalign",  32'(misalign_mem_o), 32'(m_mis));
    chk("req",       32'(dram_req_o), 32'(m_wait));
    chk("stall",     32'(stall_ex_o), 32'(m_wait && !dram_ack_i));
    chk("be",        32'(dram_be_o), 32'(be));
    chk("load_data", load_data_mem_o, m_ld_data);
    chk("wdata",     dram_wdata_o, wd);
    if (m_wait) begin
      chk("addr", dram_addr_o, m_alu & 32'hFFFF_FFFC);
      chk("we",   32'(dram_we_o), 32'(m_we));
    end
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic tick();
    #1 compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_nop();
    flush_i = 0; dram_ack_i = 0; dram_rdata_i = 0;
    pc_ex_i = 0; pc4_ex_i = 0; alu_result_ex_i = 0; rD2_ex_i = 0;
    instr_valid_ex_i = 0; rf_we_ex_i = 0; dram_we_ex_i = 0; is_load_ex_i = 0;
    load_uns_ex_i = 0; wd_sel_ex_i = 0; mem_size_ex_i = 0; wr_ex_i = 0;
  endtask

  task automatic set_instr(input logic rfwe, input logic we, input logic ld, input logic [1:0] sz,
                           input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] wr);
    instr_valid_ex_i = 1; rf_we_ex_i = rfwe; dram_we_ex_i = we; is_load_ex_i = ld;
    mem_size_ex_i = sz; alu_result_ex_i = alu; rD2_ex_i = rd2; wr_ex_i = wr;
    pc_ex_i = 32'h1000 + 32'(cyc * 4); pc4_ex_i = pc_ex_i + 4; wd_sel_ex_i = 2'b01;
  endtask

  initial begin
    model_clear_fields();
    m_ld_data = 0;
    set_nop();
    rst = 1;
    @(negedge clk);
    tick(); tick();
    rst = 0;
    chk("rst_req", 32'(dram_req_o), 0);
    chk("rst_be", 32'(dram_be_o), 0);
    chk("rst_load_data", load_data_mem_o, 0);
    chk("rst_misalign", 32'(misalign_mem_o), 0);

    // ALU op pass-through
    set_instr(1, 0, 0, 2'b10, 32'h1234, 0, 5);
    tick(); set_nop();
    chk("alu_wr", 32'(wr_mem_o), 5);
    chk("alu_res", alu_result_mem_o, 32'h1234);
    chk("alu_req", 32'(dram_req_o), 0);
    #1 chk("alu_stall", 32'(stall_ex_o), 0);

    // Store byte at 0x103, ack after two stalled cycles
    set_instr(0, 1, 0, 2'b00, 32'h103, 32'hAB, 0);
    tick(); set_nop();
    chk("sb_addr", dram_addr_o, 32'h100);
    chk("sb_be", 32'(dram_be_o), 32'h8);
    chk("sb_wdata", dram_wdata_o, 32'hAB00_0000);
    #1 chk("sb_stall1", 32'(stall_ex_o), 1);
    tick();
    chk("sb_stall2", 32'(stall_ex_o), 1);
    dram_ack_i = 1;
    tick(); dram_ack_i = 0;
    chk("sb_idle", 32'(dram_req_o), 0);

    // Load word with immediate ack; next instruction captured on the ack edge
    set_instr(1, 0, 1, 2'b10, 32'h200, 0, 4);
    tick();
    set_instr(1, 0, 0, 2'b10, 32'h55, 0, 7);
    dram_ack_i = 1; dram_rdata_i = 32'hDEAD_BEEF;
    #1 chk("lw_stall", 32'(stall_ex_o), 0);
    tick(); set_nop();
    chk("lw_data", load_data_mem_o, 32'hDEAD_BEEF);
    chk("lw_next_wr", 32'(wr_mem_o), 7);

    // Misaligned half load
    set_instr(1, 0, 1, 2'b01, 32'h201, 0, 6);
    tick(); set_nop();
    chk("mis_flag", 32'(misalign_mem_o), 1);
    chk("mis_rfwe", 32'(rf_we_mem_o), 0);
    chk("mis_req", 32'(dram_req_o), 0);
    tick();
    chk("mis_req2", 32'(dram_req_o), 0);

    // Flush in IDLE, then flush during WAIT
    set_instr(0, 1, 0, 2'b10, 32'h40, 32'h1, 0);
    flush_i = 1;
    tick(); set_nop();
    chk("fl_valid", 32'(instr_valid_mem_o), 0);
    chk("fl_req", 32'(dram_req_o), 0);
    set_instr(1, 0, 1, 2'b10, 32'h80, 0, 9);
    tick();
    set_instr(1, 0, 0, 2'b10, 32'h999, 0, 3);
    flush_i = 1;
    tick();
    chk("flw_wr", 32'(wr_mem_o), 9);
    chk("flw_alu", alu_result_mem_o, 32'h80);
    chk("flw_req", 32'(dram_req_o), 1);
    flush_i = 0; dram_ack_i = 1; dram_rdata_i = 32'hCAFE_0001;
    tick(); set_nop();
    chk("flw_next", 32'(wr_mem_o), 3);

    // Back-to-back loads, then reset mid-WAIT
    set_instr(1, 0, 1, 2'b10, 32'h10, 0, 1);
    tick();
    chk("b2b_addr0", dram_addr_o, 32'h10);
    set_instr(1, 0, 1, 2'b10, 32'h14, 0, 2);
    dram_ack_i = 1; dram_rdata_i = 32'h1111_1111;
    tick();
    chk("b2b_addr1", dram_addr_o, 32'h14);
    chk("b2b_req", 32'(dram_req_o), 1);
    chk("b2b_data0", load_data_mem_o, 32'h1111_1111);
    set_nop(); dram_ack_i = 1; dram_rdata_i = 32'h2222_2222;
    tick(); set_nop();
    chk("b2b_data1", load_data_mem_o, 32'h2222_2222);
    chk("b2b_idle", 32'(dram_req_o), 0);
    set_instr(1, 0, 1, 2'b10, 32'h20, 0, 1);
    tick(); set_nop();
    rst = 1;
    tick();
    rst = 0;
    chk("rstw_req", 32'(dram_req_o), 0);
    chk("rstw_be", 32'(dram_be_o), 0);
    #1 chk("rstw_stall", 32'(stall_ex_o), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int kind;
      rst     = ($urandom_range(0, 199) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      kind    = $urandom_range(0, 2);
      instr_valid_ex_i = ($urandom_range(0, 3) != 0);
      is_load_ex_i     = (kind == 1);
      dram_we_ex_i     = (kind == 2);
      rf_we_ex_i       = 1'($urandom);
      load_uns_ex_i    = 1'($urandom);
      mem_size_ex_i    = 2'($urandom);
      wd_sel_ex_i      = 2'($urandom);
      wr_ex_i          = 5'($urandom);
      alu_result_ex_i  = $urandom;
      rD2_ex_i         = $urandom;
      pc_ex_i          = $urandom & 32'hFFFF_FFFC;
      pc4_ex_i         = pc_ex_i + 4;
      dram_rdata_i     = $urandom;
      dram_ack_i       = rst ? 1'b0 : ($urandom_range(0, 2) == 0);
      tick();
    end
    rst = 0;
    set_nop();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
